// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time instruction-memory writer. Takes a byte stream
//                (valid/ready) made of a 2-byte little-endian word count N
//                followed by N little-endian 32-bit words, and writes each
//                word to consecutive IMEM word addresses starting at 0.
//                Keeps the core in hold until the load completes, and counts
//                words whose opcode field is outside the supported set.
//  Ports       : i_clk, i_rst            clock / async active-high reset
//                i_in_valid, o_in_ready  byte handshake, i_in_data byte
//                i_start                 re-arm pulse from DONE / ERROR
//                o_imem_we/addr/wdata    registered IMEM write port
//                o_core_hold             1 = core held
//                o_load_done, o_load_err status levels
//                o_bad_opcode_cnt        saturating unsupported-opcode count
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [7:0]            i_in_data,
    input  logic                  i_start,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]           o_imem_wdata,
    output logic                  o_core_hold,
    output logic                  o_load_done,
    output logic                  o_load_err,
    output logic [CNT_WIDTH-1:0]  o_bad_opcode_cnt
);

    localparam int unsigned c_DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_hdr_lo;
    logic [15:0]           r_n;
    logic [23:0]           r_word;       // first three bytes of the word
    logic [1:0]            r_byte_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]           r_imem_wdata;
    logic [CNT_WIDTH-1:0]  r_bad_cnt;

    logic                  w_in_ready;
    logic                  w_core_hold;
    logic                  w_load_done;
    logic                  w_load_err;
    logic                  w_accept;
    logic [15:0]           w_hdr_n;
    logic                  w_last;
    logic                  w_opc_ok;

    assign w_accept = i_in_valid && w_in_ready;
    assign w_hdr_n  = {i_in_data, r_hdr_lo};
    // Widened so that N == DEPTH compares correctly against the last index.
    assign w_last   = ((32'(r_idx) + 32'd1) == 32'(r_n));

    // Opcode of the word currently being written (valid in WRITE).
    always_comb begin
        w_opc_ok = 1'b0;
        case (r_imem_wdata[6:0])
            7'b0110011, 7'b0010011, 7'b0000011,
            7'b0100011, 7'b1100011, 7'b0010111,
            7'b0110111, 7'b1101111, 7'b1100111: w_opc_ok = 1'b1;
            default:                            w_opc_ok = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_HDR0;
        else       r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_core_hold = 1'b1;
        w_load_done = 1'b0;
        w_load_err  = 1'b0;
        case (r_state)
            S_HDR0: begin
                w_in_ready = 1'b1;
                if (w_accept) w_state_nxt = S_HDR1;
            end
            S_HDR1: begin
                w_in_ready = 1'b1;
                if (w_accept) begin
                    if (w_hdr_n == 16'd0)             w_state_nxt = S_DONE;
                    else if (32'(w_hdr_n) > c_DEPTH)  w_state_nxt = S_ERROR;
                    else                              w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_in_ready = 1'b1;
                if (w_accept && (r_byte_cnt == 2'd3)) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_state_nxt = w_last ? S_DONE : S_DATA;
            end
            S_DONE: begin
                w_core_hold = 1'b0;
                w_load_done = 1'b1;
                if (i_start) w_state_nxt = S_HDR0;
            end
            S_ERROR: begin
                w_load_err = 1'b1;
                if (i_start) w_state_nxt = S_HDR0;
            end
            default: w_state_nxt = S_HDR0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: header capture, word assembly, IMEM write port, counters
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hdr_lo     <= 8'd0;
            r_n          <= 16'd0;
            r_word       <= 24'd0;
            r_byte_cnt   <= 2'd0;
            r_idx        <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 32'd0;
            r_bad_cnt    <= '0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                S_HDR0: begin
                    if (w_accept) r_hdr_lo <= i_in_data;
                end
                S_HDR1: begin
                    if (w_accept) begin
                        r_n        <= w_hdr_n;
                        r_byte_cnt <= 2'd0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0:    r_word[7:0]   <= i_in_data;
                            2'd1:    r_word[15:8]  <= i_in_data;
                            2'd2:    r_word[23:16] <= i_in_data;
                            default: begin
                                // Fourth byte: launch the write directly
                                // from the incoming byte.
                                r_imem_we    <= 1'b1;
                                r_imem_addr  <= r_idx;
                                r_imem_wdata <= {i_in_data, r_word};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    r_idx <= r_idx + 1'b1;
                    if (!w_opc_ok && (r_bad_cnt != {CNT_WIDTH{1'b1}}))
                        r_bad_cnt <= r_bad_cnt + 1'b1;
                end
                S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_bad_cnt  <= '0;
                        r_idx      <= '0;
                        r_byte_cnt <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready       = w_in_ready;
    assign o_core_hold      = w_core_hold;
    assign o_load_done      = w_load_done;
    assign o_load_err       = w_load_err;
    assign o_imem_we        = r_imem_we;
    assign o_imem_addr      = r_imem_addr;
    assign o_imem_wdata     = r_imem_wdata;
    assign o_bad_opcode_cnt = r_bad_cnt;

endmodule
`default_nettype wire
